dataframe_receiver: RTL

Receive-side counterpart of the data-frame generator. Consumes the per-channel AXI-Stream frame stream (header beat, ADC payload beats, footer beat marked by TLAST), checks it, strips header and footer, and forwards the ADC payload as a clean AXI-Stream with TLAST on the last sample beat. Per-frame metadata and status are reported once per frame. Error counters are kept. It sits at the consuming end of the link (loopback verification, or downstream processing/DMA ingestion).

---
 rtl/dataframe_receiver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dataframe_receiver.sv
// Receive side of the channel frame link: checks header/footer beats, strips them and
// forwards the payload as a clean AXI-Stream, reporting per-frame status and counters.
module dataframe_receiver #(
   parameter int DATA_WIDTH        = 128,
   parameter int CHANNEL_ID        = 0,
   parameter int MAX_PAYLOAD_BEATS = 512
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
   input  logic [DATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
   input  logic                      S_AXIS_TVALID,
   input  logic                      S_AXIS_TLAST,
   output logic                      S_AXIS_TREADY,
   output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [DATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
   output logic                      M_AXIS_TVALID,
   output logic                      M_AXIS_TLAST,
   input  logic                      M_AXIS_TREADY,
   output logic                      FRAME_DONE,
   output logic [4:0]                FRAME_STATUS,
   output logic [47:0]               HDR_TIMESTAMP,
   output logic [15:0]               HDR_TRIGGER_INFO,
   output logic [31:0]               FTR_CHARGE_SUM,
   output logic [15:0]               FTR_BEAT_COUNT,
   output logic [31:0]               FRAME_COUNT,
   output logic [15:0]               ERROR_COUNT,
   output logic [1:0]                dbg_state
);

   // Both stream interfaces use plain AXI-Stream valid/ready: a beat transfers on a rising
   // edge where valid and ready are both high; valid never waits on ready and, once raised,
   // valid and data hold until the transfer.

   localparam int KW = DATA_WIDTH / 8;
   localparam int CW = $clog2(MAX_PAYLOAD_BEATS + 2);

   localparam logic [1:0] ST_HEADER  = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   localparam logic [7:0]    HDR_MAGIC = 8'hAA;
   localparam logic [7:0]    FTR_MAGIC = 8'h55;
   localparam logic [7:0]    CH_EXP    = 8'(CHANNEL_ID);
   localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_PAYLOAD_BEATS);
   localparam logic [CW-1:0] CNT_SAT   = CW'(MAX_PAYLOAD_BEATS + 1);

   logic [1:0]            state;
   logic                  run;
   logic                  hold_valid;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  out_valid;
   logic                  out_last;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CW-1:0]         beat_cnt;
   logic [4:0]            status_acc;
   logic [47:0]           ts_cap;
   logic [15:0]           trig_cap;

   logic       accept;
   logic       keep_bad;
   logic       ch_bad;
   logic       done_fire;
   logic [4:0] hdr_bits;
   logic [4:0] pay_bits;
   logic [4:0] ftr_bits;
   logic [4:0] done_status;

   // Status bit order: {ch_err, tkeep_err, len_err, footer_err, header_err}
   always_comb begin
      S_AXIS_TREADY = 1'b0;
      if (run) begin
         if (state == ST_PAYLOAD) S_AXIS_TREADY = M_AXIS_TREADY | ~hold_valid;
         else                     S_AXIS_TREADY = ~hold_valid;
      end
      accept    = S_AXIS_TVALID & S_AXIS_TREADY;
      done_fire = accept & S_AXIS_TLAST;
      keep_bad  = (S_AXIS_TKEEP != {KW{1'b1}});
      ch_bad    = (S_AXIS_TDATA[119:112] != CH_EXP);
      hdr_bits  = {ch_bad, keep_bad, S_AXIS_TLAST, 1'b0,
                   (S_AXIS_TDATA[127:120] != HDR_MAGIC) | S_AXIS_TLAST};
      pay_bits  = {1'b0, keep_bad, beat_cnt >= CNT_MAX, 2'b00};
      ftr_bits  = {ch_bad, keep_bad, S_AXIS_TDATA[111:96] != 16'(beat_cnt),
                   S_AXIS_TDATA[127:120] != FTR_MAGIC, 1'b0};
      case (state)
         ST_HEADER:  done_status = hdr_bits;
         ST_PAYLOAD: done_status = status_acc | ftr_bits;
         default:    done_status = status_acc | {1'b0, keep_bad, 3'b000};
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state            <= ST_HEADER;
         run              <= 1'b0;
         hold_valid       <= 1'b0;
         hold_data        <= '0;
         out_valid        <= 1'b0;
         out_last         <= 1'b0;
         out_data         <= '0;
         beat_cnt         <= '0;
         status_acc       <= '0;
         ts_cap           <= '0;
         trig_cap         <= '0;
         FRAME_DONE       <= 1'b0;
         FRAME_STATUS     <= '0;
         HDR_TIMESTAMP    <= '0;
         HDR_TRIGGER_INFO <= '0;
         FTR_CHARGE_SUM   <= '0;
         FTR_BEAT_COUNT   <= '0;
         FRAME_COUNT      <= '0;
         ERROR_COUNT      <= '0;
      end else begin
         run        <= 1'b1;
         FRAME_DONE <= 1'b0;
         if (M_AXIS_TREADY) out_valid <= 1'b0;

         if (accept) begin
            case (state)
               ST_HEADER: begin
                  status_acc <= hdr_bits;
                  if (!S_AXIS_TLAST) begin
                     if (S_AXIS_TDATA[127:120] == HDR_MAGIC) begin
                        ts_cap   <= S_AXIS_TDATA[111:64];
                        trig_cap <= S_AXIS_TDATA[63:48];
                        beat_cnt <= '0;
                        state    <= ST_PAYLOAD;
                     end else begin
                        state <= ST_DISCARD;
                     end
                  end
               end
               ST_PAYLOAD: begin
                  // Accepting any beat here implies M_AXIS_TREADY whenever a beat is held,
                  // so the output register is always free to take it.
                  if (hold_valid) begin
                     out_valid <= 1'b1;
                     out_data  <= hold_data;
                     out_last  <= S_AXIS_TLAST;
                  end
                  if (!S_AXIS_TLAST) begin
                     hold_valid <= 1'b1;
                     hold_data  <= S_AXIS_TDATA;
                     status_acc <= status_acc | pay_bits;
                     if (beat_cnt != CNT_SAT) beat_cnt <= beat_cnt + CW'(1);
                  end else begin
                     hold_valid       <= 1'b0;
                     HDR_TIMESTAMP    <= ts_cap;
                     HDR_TRIGGER_INFO <= trig_cap;
                     FTR_CHARGE_SUM   <= S_AXIS_TDATA[95:64];
                     FTR_BEAT_COUNT   <= S_AXIS_TDATA[111:96];
                     state            <= ST_HEADER;
                  end
               end
               default: begin
                  status_acc <= done_status;
                  if (S_AXIS_TLAST) state <= ST_HEADER;
               end
            endcase
         end

         if (done_fire) begin
            FRAME_DONE   <= 1'b1;
            FRAME_STATUS <= done_status;
            FRAME_COUNT  <= FRAME_COUNT + 32'd1;
            if ((done_status != 5'd0) && (ERROR_COUNT != 16'hFFFF))
               ERROR_COUNT <= ERROR_COUNT + 16'd1;
         end
      end
   end

   assign M_AXIS_TDATA  = out_data;
   assign M_AXIS_TKEEP  = {KW{1'b1}};
   assign M_AXIS_TVALID = out_valid;
   assign M_AXIS_TLAST  = out_last;
   assign dbg_state     = state;

endmodule
